// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with a valid/ready transmit FIFO, runtime
//               parity/stop-bit selection and back-to-back framing.
//               Optional line-break support when UART_TX_BREAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ClkFreq   = 10_000_000,
    parameter int BaudRate  = 115200,
    parameter int DataBits  = 8,
    parameter int FifoDepth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_valid,
    input  logic [DataBits-1:0]          tx_data,
    output logic                         tx_ready,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                         tx_break,
`endif
    output logic                         tx,
    output logic                         tx_busy,
    output logic                         tx_done,
    output logic [$clog2(FifoDepth):0]   fifo_level
);

    localparam int c_BAUDS_PER_BIT = ClkFreq / BaudRate;
    localparam int c_CNT_W         = $clog2(c_BAUDS_PER_BIT);
    localparam int c_ADDR_W        = $clog2(FifoDepth);
    localparam int c_IDX_W         = $clog2(DataBits);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(c_BAUDS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(DataBits - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_ADDR_W:0]   c_PTR_ONE  = (c_ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP1    = 3'd4,
        S_STOP2    = 3'd5,
        S_BREAK    = 3'd6,
        S_BRK_WAIT = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_IDX_W-1:0]     idx_q, idx_d;
    logic [DataBits-1:0]    shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;
    logic [c_ADDR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [DataBits-1:0]    mem_q [FifoDepth];

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_bit_end;
    logic                   w_break;
    logic                   w_launch;
    logic                   w_frame_end;
    logic [DataBits-1:0]    w_head;

`ifdef UART_TX_BREAK_EN
    assign w_break = tx_break;
`else
    assign w_break = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]) &&
                       (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]);
    assign w_push    = tx_valid && !w_full;
    assign w_head    = mem_q[rd_ptr_q[c_ADDR_W-1:0]];
    assign w_bit_end = (cnt_q == c_CNT_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        w_launch    = 1'b0;
        w_frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_break) begin
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
                end else if (!w_empty) begin
                    w_launch = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (idx_q == c_IDX_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        idx_d   = idx_q + c_IDX_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
            end
            S_STOP1: begin
                if (w_bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_bit_end) begin
                    w_frame_end = 1'b1;
                end
            end
            S_BREAK: begin
                tx_d = 1'b0;
                if (!w_break) begin
                    state_d = S_BRK_WAIT;
                    tx_d    = 1'b1;
                end
            end
            S_BRK_WAIT: begin
                tx_d = 1'b1;
                if (w_break) begin
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
                end else if (w_bit_end) begin
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Chaining straight into the next frame keeps the line gap-free.
        if (w_frame_end) begin
            if (w_break) begin
                state_d = S_BREAK;
                tx_d    = 1'b0;
            end else if (!w_empty) begin
                w_launch = 1'b1;
            end else begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        end

        if (w_launch) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            shift_d  = w_head;
            par_en_d = (parity_mode != 2'b00);
            stop2_d  = stop2;
            if (parity_mode == 2'b01) begin
                par_bit_d = ~^w_head;
            end else if (parity_mode == 2'b10) begin
                par_bit_d = ^w_head;
            end else begin
                par_bit_d = 1'b1;
            end
            state_d  = S_START;
            tx_d     = 1'b0;
        end

        if ((state_d != state_q) || w_bit_end ||
            (state_q == S_IDLE) || (state_q == S_BREAK)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_ADDR_W-1:0]] <= tx_data;
        end
    end

    assign tx         = tx_q;
    assign tx_ready   = !w_full;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign tx_busy    = !(state_q inside {S_IDLE, S_BREAK, S_BRK_WAIT});
    assign tx_done    = w_bit_end &&
                        (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));

endmodule
`default_nettype wire
